// File: rtl/hex_display_ctrl_pkg.sv
// ============================================================================
// hex_display_ctrl_pkg : active-low seven-segment glyph constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package hex_display_ctrl_pkg;

   // Segment bit order: bit0=a, bit1=b, ... bit6=g; a 0 lights the segment.
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   localparam seg_t GLYPH_0 = 7'h40;
   localparam seg_t GLYPH_1 = 7'h79;
   localparam seg_t GLYPH_2 = 7'h24;
   localparam seg_t GLYPH_3 = 7'h30;
   localparam seg_t GLYPH_4 = 7'h19;
   localparam seg_t GLYPH_5 = 7'h12;
   localparam seg_t GLYPH_6 = 7'h02;
   localparam seg_t GLYPH_7 = 7'h78;
   localparam seg_t GLYPH_8 = 7'h00;
   localparam seg_t GLYPH_9 = 7'h10;
   localparam seg_t GLYPH_A = 7'h08;
   localparam seg_t GLYPH_B = 7'h03;
   localparam seg_t GLYPH_C = 7'h46;
   localparam seg_t GLYPH_D = 7'h21;
   localparam seg_t GLYPH_E = 7'h06;
   localparam seg_t GLYPH_F = 7'h0E;

endpackage

`default_nettype wire

// File: rtl/hex_display_ctrl_glyph.sv
// ============================================================================
// hex_glyph : combinational 4-bit hex nibble to active-low 7-segment pattern
// Revision: 1.0
// ============================================================================
`default_nettype none

module hex_glyph
   import hex_display_ctrl_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (nibble_i)
         4'h0: seg_o = GLYPH_0;
         4'h1: seg_o = GLYPH_1;
         4'h2: seg_o = GLYPH_2;
         4'h3: seg_o = GLYPH_3;
         4'h4: seg_o = GLYPH_4;
         4'h5: seg_o = GLYPH_5;
         4'h6: seg_o = GLYPH_6;
         4'h7: seg_o = GLYPH_7;
         4'h8: seg_o = GLYPH_8;
         4'h9: seg_o = GLYPH_9;
         4'hA: seg_o = GLYPH_A;
         4'hB: seg_o = GLYPH_B;
         4'hC: seg_o = GLYPH_C;
         4'hD: seg_o = GLYPH_D;
         4'hE: seg_o = GLYPH_E;
         4'hF: seg_o = GLYPH_F;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/hex_display_ctrl.sv
// ============================================================================
// hex_display_ctrl : N-digit hex display with frame-synchronous commit,
//                    leading-zero blanking, blinking, parallel and scanned outputs
// Revision: 1.0
// ============================================================================
`default_nettype none

module hex_display_ctrl
   import hex_display_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int BLINK_DIV  = 25000000
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   output logic                    load_ack,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    enable,
   output logic [7*NUM_DIGITS-1:0] seg_par,
   output logic [6:0]              seg_mux,
   output logic [NUM_DIGITS-1:0]   dig_sel_n
);

   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = $clog2(BLINK_DIV);
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   logic [4*NUM_DIGITS-1:0] pending_q;
   logic                    pending_flag_q;
   logic [4*NUM_DIGITS-1:0] active_q;
   logic [SCAN_W-1:0]       scan_cnt_q;
   logic [IDX_W-1:0]        scan_idx_q;
   logic [BLINK_W-1:0]      blink_cnt_q;
   logic                    blink_phase_q;
   logic                    load_ack_q;
   logic [7*NUM_DIGITS-1:0] seg_par_q;
   logic [6:0]              seg_mux_q;
   logic [NUM_DIGITS-1:0]   dig_sel_n_q;

   logic                    tick_w;
   logic                    boundary_w;
   logic                    commit_w;
   logic [7*NUM_DIGITS-1:0] glyph_w;
   logic [7*NUM_DIGITS-1:0] seg_par_d;
   logic [6:0]              seg_mux_d;
   logic [NUM_DIGITS-1:0]   dig_sel_n_d;

   assign tick_w     = (scan_cnt_q == SCAN_LAST);
   assign boundary_w = tick_w && (scan_idx_q == IDX_LAST);
   assign commit_w   = boundary_w && pending_flag_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_glyph
         hex_glyph u_glyph (
            .nibble_i (active_q[4*gi +: 4]),
            .seg_o    (glyph_w[7*gi +: 7])
         );
      end
   endgenerate

   // Walk from the most significant digit down so the zero run is known per digit.
   always_comb begin : p_pattern
      logic zero_run;
      zero_run  = 1'b1;
      seg_par_d = {NUM_DIGITS{SEG_BLANK}};
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (active_q[4*i +: 4] == 4'h0);
         if (!enable) begin
            seg_par_d[7*i +: 7] = SEG_BLANK;
         end else if (blank_lz && (i != 0) && zero_run) begin
            seg_par_d[7*i +: 7] = SEG_BLANK;
         end else if (blink_phase_q && blink_mask[i]) begin
            seg_par_d[7*i +: 7] = SEG_BLANK;
         end else begin
            seg_par_d[7*i +: 7] = glyph_w[7*i +: 7];
         end
      end
   end

   always_comb begin
      seg_mux_d   = SEG_BLANK;
      dig_sel_n_d = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (scan_idx_q == IDX_W'(i)) begin
            seg_mux_d      = seg_par_d[7*i +: 7];
            dig_sel_n_d[i] = !enable;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q      <= '0;
         pending_flag_q <= 1'b0;
         active_q       <= '0;
         scan_cnt_q     <= '0;
         scan_idx_q     <= '0;
         blink_cnt_q    <= '0;
         blink_phase_q  <= 1'b0;
         load_ack_q     <= 1'b0;
         seg_par_q      <= '1;
         seg_mux_q      <= '1;
         dig_sel_n_q    <= '1;
      end else begin
         scan_cnt_q <= tick_w ? '0 : scan_cnt_q + 1'b1;
         if (tick_w) begin
            scan_idx_q <= (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
         end

         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= !blink_phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end

         // A load on the boundary cycle stays pending; the commit uses the old copy.
         load_ack_q <= commit_w;
         if (commit_w) begin
            active_q <= pending_q;
         end
         if (load) begin
            pending_q      <= value;
            pending_flag_q <= 1'b1;
         end else if (commit_w) begin
            pending_flag_q <= 1'b0;
         end

         seg_par_q   <= seg_par_d;
         seg_mux_q   <= seg_mux_d;
         dig_sel_n_q <= dig_sel_n_d;
      end
   end

   assign load_ack  = load_ack_q;
   assign seg_par   = seg_par_q;
   assign seg_mux   = seg_mux_q;
   assign dig_sel_n = dig_sel_n_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
// ============================================================================
// tb_hex_display_ctrl : directed scoreboard bench for hex_display_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hex_display_ctrl;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   value;
   logic          load;
   logic          load_ack;
   logic          blank_lz;
   logic [3:0]    blink_mask;
   logic          enable;
   logic [27:0]   seg_par;
   logic [6:0]    seg_mux;
   logic [3:0]    dig_sel_n;

   hex_display_ctrl #(
      .NUM_DIGITS (N),
      .SCAN_DIV   (4),
      .BLINK_DIV  (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .value      (value),
      .load       (load),
      .load_ack   (load_ack),
      .blank_lz   (blank_lz),
      .blink_mask (blink_mask),
      .enable     (enable),
      .seg_par    (seg_par),
      .seg_mux    (seg_mux),
      .dig_sel_n  (dig_sel_n)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;
   logic [27:0] exp_q[$];
   bit          pend_model  = 1'b0;

   localparam logic [27:0] P0     = {7'h40, 7'h40, 7'h40, 7'h40};
   localparam logic [27:0] P12AF  = {7'h79, 7'h24, 7'h08, 7'h0E};
   localparam logic [27:0] P2222  = {7'h24, 7'h24, 7'h24, 7'h24};
   localparam logic [27:0] P0050  = {7'h7F, 7'h7F, 7'h12, 7'h40};
   localparam logic [27:0] PZERO  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
   localparam logic [27:0] P3456  = {7'h30, 7'h19, 7'h12, 7'h02};
   localparam logic [27:0] P3456B = {7'h30, 7'h19, 7'h12, 7'h7F};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic align(input int phase);
      for (int k = 0; k < 16; k++) begin
         if (cyc % 16 == phase) break;
         step();
      end
   endtask

   task automatic check_scan(input string tag, input logic [27:0] exp_par, input int n);
      for (int k = 0; k < n; k++) begin
         int         idx;
         logic [3:0] ed;
         logic [6:0] em;
         step();
         idx = ((cyc - 1) / 4) % 4;
         ed  = ~(4'b0001 << idx);
         em  = exp_par[7*idx +: 7];
         check({tag, "_dig"}, {28'd0, dig_sel_n}, {28'd0, ed});
         check({tag, "_mux"}, {25'd0, seg_mux}, {25'd0, em});
         check({tag, "_par"}, {4'd0, seg_par}, {4'd0, exp_par});
         check({tag, "_ack"}, {31'd0, load_ack}, 32'd0);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [27:0] exp_par);
      value = v;
      load  = 1'b1;
      if (pend_model && exp_q.size() > 0) exp_q[exp_q.size() - 1] = exp_par;
      else exp_q.push_back(exp_par);
      pend_model = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic wait_ack(input string tag, input logic [27:0] hold_par);
      bit          got;
      logic [27:0] e;
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (load_ack) begin
            got = 1'b1;
            break;
         end
         check({tag, "_hold"}, {4'd0, seg_par}, {4'd0, hold_par});
      end
      if (!got) begin
         check({tag, "_timeout"}, {31'd0, load_ack}, 32'd1);
      end else begin
         check({tag, "_ackphase"}, cyc % 16, 32'd0);
         pend_model = 1'b0;
         if (exp_q.size() == 0) begin
            check({tag, "_spurious"}, {31'd0, load_ack}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            step();
            check({tag, "_commit"}, {4'd0, seg_par}, {4'd0, e});
         end
      end
   endtask

   initial begin
      reset      = 1'b1;
      load       = 1'b0;
      value      = '0;
      blank_lz   = 1'b0;
      blink_mask = '0;
      enable     = 1'b1;
      step();
      step();
      check("rst_par", {4'd0, seg_par}, {4'd0, 28'hFFFFFFF});
      check("rst_mux", {25'd0, seg_mux}, 32'h7F);
      check("rst_dig", {28'd0, dig_sel_n}, 32'hF);
      check("rst_ack", {31'd0, load_ack}, 32'd0);
      reset = 1'b0;
      cyc   = 0;

      check_scan("idle", P0, 16);

      do_load(16'h12AF, P12AF);
      wait_ack("ld12af", P0);
      check_scan("s12af", P12AF, 20);

      align(1);
      do_load(16'h1111, {7'h79, 7'h79, 7'h79, 7'h79});
      step();
      do_load(16'h2222, P2222);
      wait_ack("ld2222", P12AF);
      check_scan("s2222", P2222, 20);

      blank_lz = 1'b1;
      do_load(16'h0050, P0050);
      wait_ack("ld0050", P2222);
      check_scan("s0050", P0050, 20);
      do_load(16'h0000, PZERO);
      wait_ack("ld0000", P0050);
      check_scan("szero", PZERO, 20);

      blank_lz = 1'b0;
      do_load(16'h3456, P3456);
      wait_ack("ld3456", P0);

      // Blink phase is anchored to reset release: phase toggles every 8 cycles.
      blink_mask = 4'b0001;
      for (int k = 0; k < 24; k++) begin
         step();
         check("blink_par", {4'd0, seg_par},
               {4'd0, ((((cyc - 1) / 8) % 2) == 1) ? P3456B : P3456});
      end

      enable = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         check("dis_par", {4'd0, seg_par}, {4'd0, 28'hFFFFFFF});
         check("dis_mux", {25'd0, seg_mux}, 32'h7F);
         check("dis_dig", {28'd0, dig_sel_n}, 32'hF);
      end
      enable     = 1'b1;
      blink_mask = '0;
      step();

      align(15);
      value = 16'hBEEF;
      load  = 1'b1;
      step();
      load  = 1'b0;
      check("bnd_noack", {31'd0, load_ack}, 32'd0);
      step();
      check("bnd_hold", {4'd0, seg_par}, {4'd0, P3456});
      step();
      step();
      reset = 1'b1;
      exp_q.delete();
      pend_model = 1'b0;
      step();
      check("rst2_par", {4'd0, seg_par}, {4'd0, 28'hFFFFFFF});
      check("rst2_dig", {28'd0, dig_sel_n}, 32'hF);
      check("rst2_ack", {31'd0, load_ack}, 32'd0);
      step();
      reset = 1'b0;
      cyc   = 0;
      check_scan("post_rst", P0, 40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
